sram_arb: RTL and testbench

SRAM_ARB -- requirements
Module: sram_arb

---
 rtl/sram_arb.sv | 232 +++++++++++++++++++++++
 tb/tb_sram_arb.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arb.sv
// SRAM arbiter: shares one 32-bit asynchronous SRAM between video word fetches and CPU accesses.
// Optional macro SRAM_ARB_FAIR_EN alternates grants between video and CPU when both are pending.
module sram_arb #(
  parameter int WS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic        cpu_ben,
  input  logic [19:0] cpu_adr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        vid_req,
  input  logic [17:0] vid_adr,
  output logic        vid_ack,
  output logic [31:0] vid_data,
  output logic [17:0] sr_adr,
  output logic [3:0]  sr_be_n,
  output logic        sr_ce_n,
  output logic        sr_oe_n,
  output logic        sr_we_n,
  output logic [31:0] sr_dout,
  output logic        sr_drv,
  input  logic [31:0] sr_din
);

  // state | meaning
  // IDLE  | no access; arbitrate pending requests
  // VRD   | video word read
  // CRD   | CPU read
  // CWS   | CPU write setup (data driven, we_n high)
  // CWP   | CPU write pulse, WS cycles
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    VRD  = 3'd1,
    CRD  = 3'd2,
    CWS  = 3'd3,
    CWP  = 3'd4
  } state_t;

  localparam logic [1:0] WP_LAST = 2'(WS - 1);

  state_t      state_q, state_d;
  logic [1:0]  wp_cnt_q, wp_cnt_d;
  logic        cpu_done_q, cpu_done_d;
  logic        vid_ack_q, vid_ack_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [31:0] vid_data_q, vid_data_d;
`ifdef SRAM_ARB_FAIR_EN
  logic        last_vid_q, last_vid_d;
`endif

  logic        sram_bound;
  logic        cpu_req;
  logic        cpu_pend;
  logic [1:0]  byte_lane;
  logic [3:0]  cpu_be_n;
  logic [7:0]  rd_byte;
  logic        grant_vid;
  logic        grant_cpu;
  logic        wp_done;

  assign sram_bound = (cpu_adr[19:6] != 14'h3FFF);
  assign cpu_req    = (cpu_rd | cpu_wr) & sram_bound;
  // cpu_done blocks a restart so the still-held request is not serviced twice
  assign cpu_pend   = cpu_req & ~cpu_done_q;
  assign cpu_stall  = cpu_req & ~cpu_done_q;
  assign byte_lane  = cpu_adr[1:0];
  assign wp_done    = (wp_cnt_q == 2'd0);

  always_comb begin
    cpu_be_n = 4'b0000;
    if (cpu_ben) begin
      cpu_be_n = 4'b1111;
      cpu_be_n[byte_lane] = 1'b0;
    end
  end

  always_comb begin
    rd_byte = sr_din[7:0];
    case (byte_lane)
      2'd0: rd_byte = sr_din[7:0];
      2'd1: rd_byte = sr_din[15:8];
      2'd2: rd_byte = sr_din[23:16];
      2'd3: rd_byte = sr_din[31:24];
      default: rd_byte = sr_din[7:0];
    endcase
  end

  always_comb begin
    grant_vid = 1'b0;
    grant_cpu = 1'b0;
    if (state_q == IDLE) begin
`ifdef SRAM_ARB_FAIR_EN
      if (last_vid_q && cpu_pend) begin
        grant_cpu = 1'b1;
      end else if (vid_req) begin
        grant_vid = 1'b1;
      end else if (cpu_pend) begin
        grant_cpu = 1'b1;
      end
`else
      if (vid_req) begin
        grant_vid = 1'b1;
      end else if (cpu_pend) begin
        grant_cpu = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    wp_cnt_d = wp_cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_vid) begin
          state_d = VRD;
        end else if (grant_cpu) begin
          state_d = cpu_rd ? CRD : CWS;
        end
      end
      VRD: state_d = IDLE;
      CRD: state_d = IDLE;
      CWS: begin
        state_d  = CWP;
        wp_cnt_d = WP_LAST;
      end
      CWP: begin
        if (wp_done) begin
          state_d = IDLE;
        end else begin
          wp_cnt_d = wp_cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_done_d  = (state_q == CRD) || ((state_q == CWP) && wp_done);
    vid_ack_d   = (state_q == VRD);
    cpu_rdata_d = cpu_rdata_q;
    vid_data_d  = vid_data_q;
    if (state_q == CRD) begin
      cpu_rdata_d = cpu_ben ? {24'h0, rd_byte} : sr_din;
    end
    if (state_q == VRD) begin
      vid_data_d = sr_din;
    end
  end

`ifdef SRAM_ARB_FAIR_EN
  always_comb begin
    last_vid_d = last_vid_q;
    if (grant_vid) begin
      last_vid_d = 1'b1;
    end else if (grant_cpu) begin
      last_vid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_vid_q <= 1'b0;
    end else begin
      last_vid_q <= last_vid_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wp_cnt_q    <= 2'd0;
      cpu_done_q  <= 1'b0;
      vid_ack_q   <= 1'b0;
      cpu_rdata_q <= 32'h0;
      vid_data_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      wp_cnt_q    <= wp_cnt_d;
      cpu_done_q  <= cpu_done_d;
      vid_ack_q   <= vid_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_data_q  <= vid_data_d;
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign vid_ack   = vid_ack_q;
  assign vid_data  = vid_data_q;

  // SRAM pins decode from state_q only, so reset forces them inactive without waiting for a clock
  always_comb begin
    sr_adr  = 18'h0;
    sr_be_n = 4'b1111;
    sr_ce_n = 1'b1;
    sr_oe_n = 1'b1;
    sr_we_n = 1'b1;
    sr_dout = 32'h0;
    sr_drv  = 1'b0;
    case (state_q)
      VRD: begin
        sr_adr  = vid_adr;
        sr_be_n = 4'b0000;
        sr_ce_n = 1'b0;
        sr_oe_n = 1'b0;
      end
      CRD: begin
        sr_adr  = cpu_adr[19:2];
        sr_be_n = cpu_be_n;
        sr_ce_n = 1'b0;
        sr_oe_n = 1'b0;
      end
      CWS, CWP: begin
        sr_adr  = cpu_adr[19:2];
        sr_be_n = cpu_be_n;
        sr_ce_n = 1'b0;
        sr_we_n = (state_q == CWP) ? 1'b0 : 1'b1;
        sr_dout = cpu_ben ? {4{cpu_wdata[7:0]}} : cpu_wdata;
        sr_drv  = 1'b1;
      end
      default: begin
        sr_adr  = 18'h0;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_arb.sv
// Directed self-checking bench for sram_arb (WS=2); expectations follow SRAM_ARB_FAIR_EN when defined.
module tb_sram_arb;

  logic        clk;
  logic        rst;
  logic        cpu_rd;
  logic        cpu_wr;
  logic        cpu_ben;
  logic [19:0] cpu_adr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        vid_req;
  logic [17:0] vid_adr;
  logic        vid_ack;
  logic [31:0] vid_data;
  logic [17:0] sr_adr;
  logic [3:0]  sr_be_n;
  logic        sr_ce_n;
  logic        sr_oe_n;
  logic        sr_we_n;
  logic [31:0] sr_dout;
  logic        sr_drv;
  logic [31:0] sr_din;

  int checks;
  int errors;

  sram_arb #(.WS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_ben   (cpu_ben),
    .cpu_adr   (cpu_adr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .vid_req   (vid_req),
    .vid_adr   (vid_adr),
    .vid_ack   (vid_ack),
    .vid_data  (vid_data),
    .sr_adr    (sr_adr),
    .sr_be_n   (sr_be_n),
    .sr_ce_n   (sr_ce_n),
    .sr_oe_n   (sr_oe_n),
    .sr_we_n   (sr_we_n),
    .sr_dout   (sr_dout),
    .sr_drv    (sr_drv),
    .sr_din    (sr_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_rd = 0; cpu_wr = 0; cpu_ben = 0; cpu_adr = 20'h0; cpu_wdata = 32'h0;
    vid_req = 0; vid_adr = 18'h0; sr_din = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    checks++; if (sr_we_n !== 1'b1) begin errors++; $display("FAIL rst_we_n got %b exp 1", sr_we_n); end
    checks++; if (sr_oe_n !== 1'b1) begin errors++; $display("FAIL rst_oe_n got %b exp 1", sr_oe_n); end
    checks++; if (sr_ce_n !== 1'b1) begin errors++; $display("FAIL rst_ce_n got %b exp 1", sr_ce_n); end
    checks++; if (sr_drv !== 1'b0) begin errors++; $display("FAIL rst_drv got %b exp 0", sr_drv); end
    checks++; if (sr_be_n !== 4'b1111) begin errors++; $display("FAIL rst_be_n got %b exp 1111", sr_be_n); end
    checks++; if (vid_ack !== 1'b0) begin errors++; $display("FAIL rst_vid_ack got %b exp 0", vid_ack); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL rst_cpu_rdata got %h exp 0", cpu_rdata); end
    checks++; if (vid_data !== 32'h0) begin errors++; $display("FAIL rst_vid_data got %h exp 0", vid_data); end
    checks++; if (sr_adr !== 18'h0) begin errors++; $display("FAIL rst_sr_adr got %h exp 0", sr_adr); end
    checks++; if (sr_dout !== 32'h0) begin errors++; $display("FAIL rst_sr_dout got %h exp 0", sr_dout); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", cpu_stall); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_word_read();
    cpu_rd = 1; cpu_ben = 0; cpu_adr = 20'h00010; sr_din = 32'h11223344;
    #1;
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL wrd_stall0 got %b exp 1", cpu_stall); end
    tick(); // CRD
    checks++; if (sr_adr !== 18'h00004) begin errors++; $display("FAIL wrd_sr_adr got %h exp 00004", sr_adr); end
    checks++; if (sr_oe_n !== 1'b0 || sr_ce_n !== 1'b0) begin errors++; $display("FAIL wrd_oe_ce got %b%b exp 00", sr_oe_n, sr_ce_n); end
    checks++; if (sr_be_n !== 4'b0000) begin errors++; $display("FAIL wrd_be_n got %b exp 0000", sr_be_n); end
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL wrd_stall1 got %b exp 1", cpu_stall); end
    tick(); // IDLE with cpu_done
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL wrd_stall2 got %b exp 0", cpu_stall); end
    checks++; if (cpu_rdata !== 32'h11223344) begin errors++; $display("FAIL wrd_rdata got %h exp 11223344", cpu_rdata); end
    checks++; if (sr_ce_n !== 1'b1) begin errors++; $display("FAIL wrd_no_restart got ce_n %b exp 1", sr_ce_n); end
    cpu_rd = 0;
    tick();
    checks++; if (sr_ce_n !== 1'b1) begin errors++; $display("FAIL wrd_idle_after got ce_n %b exp 1", sr_ce_n); end
  endtask

  task automatic test_byte_write();
    int we_low;
    we_low = 0;
    cpu_wr = 1; cpu_ben = 1; cpu_adr = 20'h00007; cpu_wdata = 32'h000000A5;
    tick(); // CWS
    checks++; if (sr_we_n !== 1'b1 || sr_ce_n !== 1'b0) begin errors++; $display("FAIL bwr_setup got we_n %b ce_n %b exp 1 0", sr_we_n, sr_ce_n); end
    checks++; if (sr_drv !== 1'b1) begin errors++; $display("FAIL bwr_drv_setup got %b exp 1", sr_drv); end
    checks++; if (sr_be_n !== 4'b0111) begin errors++; $display("FAIL bwr_be_n got %b exp 0111", sr_be_n); end
    checks++; if (sr_dout !== 32'hA5A5A5A5) begin errors++; $display("FAIL bwr_dout got %h exp a5a5a5a5", sr_dout); end
    checks++; if (sr_adr !== 18'h00001) begin errors++; $display("FAIL bwr_sr_adr got %h exp 00001", sr_adr); end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (sr_we_n === 1'b0) we_low++;
      if (i == 2) begin
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL bwr_done_stall got %b exp 0", cpu_stall); end
        checks++; if (sr_drv !== 1'b0) begin errors++; $display("FAIL bwr_drv_idle got %b exp 0", sr_drv); end
        cpu_wr = 0; cpu_ben = 0;
      end
    end
    checks++; if (we_low != 2) begin errors++; $display("FAIL bwr_we_width got %0d exp 2", we_low); end
  endtask

  task automatic test_byte_read();
    cpu_rd = 1; cpu_ben = 1; cpu_adr = 20'h00006; sr_din = 32'hDEADBEEF;
    tick(); // CRD
    checks++; if (sr_be_n !== 4'b1011) begin errors++; $display("FAIL brd_be_n got %b exp 1011", sr_be_n); end
    tick();
    checks++; if (cpu_rdata !== 32'h000000AD) begin errors++; $display("FAIL brd_rdata got %h exp 000000ad", cpu_rdata); end
    cpu_rd = 0; cpu_ben = 0;
    tick();
  endtask

  task automatic test_video_priority();
    vid_req = 1; vid_adr = 18'h2ABCD; cpu_rd = 1; cpu_adr = 20'h00020; sr_din = 32'hCAFEF00D;
    tick(); // VRD
    checks++; if (sr_adr !== 18'h2ABCD || sr_oe_n !== 1'b0) begin errors++; $display("FAIL vp_vrd got adr %h oe_n %b exp 2abcd 0", sr_adr, sr_oe_n); end
    checks++; if (sr_be_n !== 4'b0000) begin errors++; $display("FAIL vp_be_n got %b exp 0000", sr_be_n); end
    checks++; if (vid_ack !== 1'b0) begin errors++; $display("FAIL vp_ack_early got %b exp 0", vid_ack); end
    vid_req = 0;
    tick(); // IDLE, ack
    checks++; if (vid_ack !== 1'b1) begin errors++; $display("FAIL vp_ack got %b exp 1", vid_ack); end
    checks++; if (vid_data !== 32'hCAFEF00D) begin errors++; $display("FAIL vp_vid_data got %h exp cafef00d", vid_data); end
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL vp_stall got %b exp 1", cpu_stall); end
    sr_din = 32'h55667788;
    tick(); // CRD
    checks++; if (sr_adr !== 18'h00008 || sr_oe_n !== 1'b0) begin errors++; $display("FAIL vp_crd got adr %h oe_n %b exp 00008 0", sr_adr, sr_oe_n); end
    checks++; if (vid_ack !== 1'b0) begin errors++; $display("FAIL vp_ack_pulse got %b exp 0", vid_ack); end
    tick();
    checks++; if (cpu_rdata !== 32'h55667788) begin errors++; $display("FAIL vp_rdata got %h exp 55667788", cpu_rdata); end
    cpu_rd = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    vid_req = 1; vid_adr = 18'h2ABCD; cpu_rd = 1; cpu_adr = 20'h00020;
    tick(); // grant 1: video in both modes
    checks++; if (sr_adr !== 18'h2ABCD || sr_ce_n !== 1'b0) begin errors++; $display("FAIL b2b_g1 got adr %h ce_n %b exp 2abcd 0", sr_adr, sr_ce_n); end
    tick(); // IDLE
    tick(); // grant 2
`ifdef SRAM_ARB_FAIR_EN
    checks++; if (sr_adr !== 18'h00008 || sr_oe_n !== 1'b0) begin errors++; $display("FAIL b2b_g2 got adr %h oe_n %b exp 00008 0", sr_adr, sr_oe_n); end
    tick();
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL b2b_done got stall %b exp 0", cpu_stall); end
`else
    checks++; if (sr_adr !== 18'h2ABCD || sr_oe_n !== 1'b0) begin errors++; $display("FAIL b2b_g2 got adr %h oe_n %b exp 2abcd 0", sr_adr, sr_oe_n); end
    tick();
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL b2b_starve got stall %b exp 1", cpu_stall); end
`endif
    tick(); // grant 3: video in both modes
    checks++; if (sr_adr !== 18'h2ABCD || sr_ce_n !== 1'b0) begin errors++; $display("FAIL b2b_g3 got adr %h ce_n %b exp 2abcd 0", sr_adr, sr_ce_n); end
    vid_req = 0; cpu_rd = 0;
    tick();
    tick();
    checks++; if (sr_ce_n !== 1'b1) begin errors++; $display("FAIL b2b_settle got ce_n %b exp 1", sr_ce_n); end
  endtask

  task automatic test_io_space();
    int active;
    active = 0;
    cpu_rd = 1; cpu_adr = 20'hFFFC4;
    #1;
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL io_stall_rd got %b exp 0", cpu_stall); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (sr_ce_n !== 1'b1) active++;
    end
    cpu_rd = 0; cpu_wr = 1;
    #1;
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL io_stall_wr got %b exp 0", cpu_stall); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (sr_ce_n !== 1'b1) active++;
    end
    checks++; if (active != 0) begin errors++; $display("FAIL io_sram_activity got %0d cycles exp 0", active); end
    cpu_wr = 0;
    tick();
  endtask

  task automatic test_reset_mid_cwp();
    cpu_wr = 1; cpu_ben = 0; cpu_adr = 20'h00100; cpu_wdata = 32'h12345678;
    tick(); // CWS
    tick(); // CWP
    checks++; if (sr_we_n !== 1'b0) begin errors++; $display("FAIL rcwp_pulse got we_n %b exp 0", sr_we_n); end
    checks++; if (sr_dout !== 32'h12345678) begin errors++; $display("FAIL rcwp_dout got %h exp 12345678", sr_dout); end
    rst = 1'b0;
    #1;
    checks++; if (sr_we_n !== 1'b1) begin errors++; $display("FAIL rcwp_we_n got %b exp 1", sr_we_n); end
    checks++; if (sr_ce_n !== 1'b1 || sr_drv !== 1'b0) begin errors++; $display("FAIL rcwp_idle got ce_n %b drv %b exp 1 0", sr_ce_n, sr_drv); end
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL rcwp_held_stall got %b exp 1", cpu_stall); end
    tick();
    rst = 1'b1;
    tick(); // re-arbitrated: CWS
    checks++; if (sr_ce_n !== 1'b0 || sr_we_n !== 1'b1 || sr_drv !== 1'b1) begin errors++; $display("FAIL rcwp_restart got ce_n %b we_n %b drv %b exp 0 1 1", sr_ce_n, sr_we_n, sr_drv); end
    tick();
    tick();
    tick(); // IDLE with cpu_done
    checks++; if (cpu_stall !== 1'b0 || sr_we_n !== 1'b1) begin errors++; $display("FAIL rcwp_finish got stall %b we_n %b exp 0 1", cpu_stall, sr_we_n); end
    cpu_wr = 0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_word_read();
    test_byte_write();
    test_byte_read();
    test_video_priority();
    test_back_to_back();
    test_io_space();
    test_reset_mid_cwp();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
